// File: rtl/spi_tx.sv
// Byte-wide SPI master transmitter, mode 0, MSB first.
// A rising edge on load_data in IDLE captures data_in and clocks it out on spi_clock/spi_data.
module spi_tx #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load_data,
  output logic       done_send,
  output logic       spi_clock,
  output logic       spi_data
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_load_prev;
  logic             r_spi_clock;
  logic             r_spi_data;
  logic             r_done;

  state_t           w_state_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic             w_spi_clock_nxt;
  logic             w_spi_data_nxt;
  logic             w_done_nxt;
  logic             w_start;
  logic             w_div_wrap;

  assign w_start    = load_data && !r_load_prev;
  assign w_div_wrap = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_load_prev <= 1'b0;
      r_spi_clock <= 1'b0;
      r_spi_data  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
      r_load_prev <= load_data;
      r_spi_clock <= w_spi_clock_nxt;
      r_spi_data  <= w_spi_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_div_cnt_nxt   = r_div_cnt;
    w_spi_clock_nxt = r_spi_clock;
    w_spi_data_nxt  = r_spi_data;
    w_done_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        w_spi_clock_nxt = 1'b0;
        w_spi_data_nxt  = 1'b0;
        if (w_start) begin
          w_shift_nxt    = data_in;
          w_spi_data_nxt = data_in[7];
          w_bit_cnt_nxt  = '0;
          w_div_cnt_nxt  = '0;
          w_state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        if (w_div_wrap) begin
          w_div_cnt_nxt = '0;
          if (!r_spi_clock) begin
            w_spi_clock_nxt = 1'b1;
          end else begin
            // Data only moves on the falling toggle, so it is settled a full half period before each rise.
            w_spi_clock_nxt = 1'b0;
            if (r_bit_cnt != 3'd7) begin
              w_shift_nxt    = {r_shift[6:0], 1'b0};
              w_spi_data_nxt = r_shift[6];
              w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
            end else begin
              w_spi_data_nxt = 1'b0;
              w_done_nxt     = 1'b1;
              w_state_nxt    = DONE;
            end
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign done_send = r_done;
  assign spi_clock = r_spi_clock;
  assign spi_data  = r_spi_data;

endmodule

// File: tb/tb_spi_tx.sv
// Scoreboard bench for spi_tx: stimulus queues expected bits/done times, a monitor checks them.
module tb_spi_tx;

  localparam int H = 2;

  typedef struct {
    logic b;
    int   c;
  } bit_exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       load_data;
  logic       done_send;
  logic       spi_clock;
  logic       spi_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit_exp_t bq[$];
  int       dq[$];

  spi_tx #(.HALF_PERIOD(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .load_data(load_data),
    .done_send(done_send),
    .spi_clock(spi_clock),
    .spi_data (spi_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising clock edge.
  initial begin : monitor
    logic     prev_sclk;
    logic     prev_data;
    logic     prev_done;
    bit_exp_t e;
    int       dexp;
    prev_sclk = 1'b0;
    prev_data = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (spi_clock && !prev_sclk) begin
        if (bq.size() == 0) begin
          chk("extra_sclk_rise", 1, 0);
        end else begin
          e = bq.pop_front();
          chk("bit_value", int'(spi_data), int'(e.b));
          chk("bit_time", cyc, e.c);
          chk("bit_stable", int'(spi_data), int'(prev_data));
        end
      end
      if (done_send) begin
        if (prev_done) chk("done_width", 2, 1);
        else if (dq.size() == 0) chk("extra_done", 1, 0);
        else begin
          dexp = dq.pop_front();
          chk("done_time", cyc, dexp);
        end
      end
      prev_sclk = spi_clock;
      prev_data = spi_data;
      prev_done = done_send;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Called at a negedge; the following rising edge is the start edge E0.
  task automatic start(input logic [7:0] d, input int nbits, input bit exp_done, output int e0);
    bit_exp_t e;
    data_in   = d;
    load_data = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      e.b = d[7-i];
      e.c = e0 + (2 * i + 1) * H;
      bq.push_back(e);
    end
    if (exp_done) dq.push_back(e0 + 16 * H);
  endtask

  initial begin : stim
    int e0;
    reset     = 1'b0;
    load_data = 1'b0;
    data_in   = 8'h00;
    #2 reset = 1'b1;
    #1;
    chk("rst_done", int'(done_send), 0);
    chk("rst_sclk", int'(spi_clock), 0);
    chk("rst_sdata", int'(spi_data), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic 0xC6, load held for 10 cycles
    start(8'hC6, 8, 1'b1, e0);
    wait_until(e0 + 9);
    load_data = 1'b0;
    wait_until(e0 + 33);

    // Held load through and past done: no retrigger
    start(8'h5A, 8, 1'b1, e0);
    wait_until(e0 + 60);
    chk("held_sclk_low", int'(spi_clock), 0);
    load_data = 1'b0;
    wait_until(e0 + 64);

    // Back-to-back 0xA5 then 0x3C, second start in the first cycle after DONE
    start(8'hA5, 8, 1'b1, e0);
    wait_until(e0);
    load_data = 1'b0;
    wait_until(e0 + 33);
    start(8'h3C, 8, 1'b1, e0);
    wait_until(e0);
    load_data = 1'b0;
    wait_until(e0 + 36);

    // Busy: load edges with data_in=0 during a 0xFF transfer are ignored
    start(8'hFF, 8, 1'b1, e0);
    wait_until(e0);
    load_data = 1'b0;
    wait_until(e0 + 5);
    data_in   = 8'h00;
    load_data = 1'b1;
    wait_until(e0 + 7);
    load_data = 1'b0;
    wait_until(e0 + 20);
    load_data = 1'b1;
    wait_until(e0 + 22);
    load_data = 1'b0;
    wait_until(e0 + 40);

    // Reset after 3 bits of 0x96; spi_data is 1 (bit 3) at that point
    start(8'h96, 3, 1'b0, e0);
    wait_until(e0);
    load_data = 1'b0;
    wait_until(e0 + 13);
    chk("pre_abort_sdata", int'(spi_data), 1);
    reset = 1'b1;
    #1;
    chk("abort_sclk", int'(spi_clock), 0);
    chk("abort_sdata", int'(spi_data), 0);
    chk("abort_done", int'(done_send), 0);
    #18;
    chk("abort_hold_sclk", int'(spi_clock), 0);
    chk("abort_hold_sdata", int'(spi_data), 0);
    chk("abort_hold_done", int'(done_send), 0);
    #1 reset = 1'b0;

    start(8'h81, 8, 1'b1, e0);
    wait_until(e0);
    load_data = 1'b0;
    wait_until(e0 + 33);

    repeat (50) @(negedge clock);
    chk("bits_left", bq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx.md
Name: spi_tx

Overview:
- Byte-wide SPI transmitter (master, mode 0, MSB first, transmit only).
- Accepts an 8-bit word on a rising edge of load_data.
- Generates spi_clock from the system clock and shifts the word out on spi_data.
- Pulses done_send when the transfer completes. Sits between a local controller and an external SPI slave.

Parameters:
- HALF_PERIOD, default 2: system-clock cycles per spi_clock half period; legal range is ≥1.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high; returns the block to idle.
- data_in, input, 8: word to transmit; sampled only at the start event.
- load_data, input, 1: start request; its rising edge starts a transfer.
- done_send, output, 1: one-cycle completion pulse.
- spi_clock, output, 1: serial clock; idles low.
- spi_data, output, 1: serial data, MSB first; valid on spi_clock rising edges.

Behaviour:
- Single clock domain; reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - spi_clock=0, spi_data=0, done_send=0.
  - state=IDLE; shift register, bit counter, divider counter = 0.
  - load_prev=0.
- Start detect: load_prev samples load_data every cycle. The start event is load_data=1 && load_prev=0, and it is honoured only in IDLE.
  - A load edge outside IDLE is ignored.
  - Holding load_data high never retriggers; a new transfer needs a low-then-high edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - spi_clock=0, spi_data=0.
  - On start event at edge E0: shift_reg<=data_in, spi_data<=data_in[7], bit_cnt<=0, div_cnt<=0, go to SHIFT.
- SHIFT:
  - div_cnt increments each cycle. When div_cnt==HALF_PERIOD-1: toggle spi_clock, div_cnt<=0.
  - Rising toggle (0→1): data is held.
  - Falling toggle (1→0), bit_cnt<7: shift left, spi_data<=next bit, bit_cnt++.
  - Falling toggle (1→0), bit_cnt==7: spi_data<=0, done_send<=1, go to DONE.
- DONE (one cycle): done_send<=0, go to IDLE.
- Timing with HALF_PERIOD=H:
  - spi_clock toggles at edges E0+k·H, for k=1..16.
  - The 8 rising spi_clock edges are at E0+(2i+1)·H, where i is the bit index from the MSB.
  - done_send is high for exactly one cycle, starting at edge E0+16·H. With H=2 that is E0+32.
  - A new start is accepted from the cycle after DONE onward.
- data_in changes during a transfer have no effect. load_data may drop at any time without aborting the transfer.
- Reset mid-transfer: all outputs are immediately 0 and state is IDLE. done_send is not asserted for the aborted word.
- spi_data is stable for a full spi_clock period around each rising edge. It changes only at E0 or at falling toggles.

Test Plan:
- Reset: assert reset for 20 ns mid-clock -> done_send=0, spi_clock=0, spi_data=0 immediately (asynchronous), and they stay 0 while reset is high.
- Basic send 0xC6 (H=2), with load_data held high for 10 cycles:
  - spi_data sampled on the 8 spi_clock rising edges = 1,1,0,0,0,1,1,0.
  - Exactly 8 rising spi_clock edges.
  - done_send high for exactly 1 cycle, 32 cycles after the start edge.
- Held load: keep load_data high through and beyond done_send -> no second transfer; spi_clock stays low after DONE.
- Back-to-back: pulse load_data with 0xA5, then after done_send pulse load_data with 0x3C -> bit streams are 10100101 then 00111100, each followed by a done_send pulse.
- Busy ignore: during a 0xFF transfer, toggle load_data with data_in=0x00 -> the stream stays all ones, a single done_send, and no extra transfer.
- Reset mid-transfer: assert reset after 3 bits of 0x96 -> spi_clock and spi_data drop to 0 at once, with no done_send. After release, a fresh load of 0x81 sends 10000001 cleanly.
